// File: rtl/axi_read_master.sv
// AXI4 read-channel master: one INCR burst per command, R beats streamed
// out through a one-entry output register, done/err pulse at the end.
// Optional R-channel idle timeout: define AXI_READ_MASTER_TIMEOUT_EN.
//
// Handshake rule on cmd, AR, R and out ports: a transfer happens on a rising
// edge where valid and ready are both high; the source holds valid and its
// payload stable until that edge.
module axi_read_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_FLUSH} state_t;

    state_t     state;
    logic [8:0] beat_cnt;   // 9 bits so len=255 (256 beats) never wraps
    logic       err_acc;
    logic       r_fire;
    logic       final_beat;
    logic       beat_err;
    logic       to_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign cmd_ready  = (state == ST_IDLE);
    assign arburst    = 2'b01;
    assign rready     = (state == ST_DATA) && (!out_valid || out_ready);
    assign r_fire     = rvalid && rready;
    assign final_beat = (beat_cnt == {1'b0, arlen});
    // A beat is bad on a non-OKAY response or when rlast disagrees with the count
    assign beat_err   = (rresp != 2'b00) || (rlast != final_beat);

`ifdef AXI_READ_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] to_cnt;

    assign to_hit = (state == ST_DATA) && rready && !rvalid &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count DATA cycles spent waiting on an idle R channel
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt <= '0;
        end else if (state != ST_DATA || r_fire) begin
            to_cnt <= '0;
        end else if (rready && !rvalid) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Command/AR/R sequencing, output register and completion pulse
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            araddr    <= '0;
            arlen     <= '0;
            arsize    <= '0;
            arvalid   <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= '0;
            err_acc   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (cmd_valid) begin
                        araddr   <= cmd_addr;
                        arlen    <= cmd_len;
                        arsize   <= cmd_size;
                        arvalid  <= 1'b1;
                        beat_cnt <= '0;
                        err_acc  <= 1'b0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_fire) begin
                        out_data  <= rdata;
                        out_valid <= 1'b1;
                        out_last  <= final_beat;
                        beat_cnt  <= beat_cnt + 9'd1;
                        err_acc   <= err_acc | beat_err;
                        // The burst ends by count; rlast only feeds the error flag
                        if (final_beat) begin
                            state <= ST_FLUSH;
                        end
                    end else begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                        if (to_hit) begin
                            err_acc <= 1'b1;
                            state   <= ST_FLUSH;
                            if (out_valid && !out_ready) begin
                                // Held beat becomes the burst's last one
                                out_last <= 1'b1;
                            end else begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (done) begin
                        // Pulse has been shown for one cycle; cmd_ready follows
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        err       <= err_acc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master with a byte-addressed RAM slave model
// (byte i holds value i). Define AXI_READ_MASTER_TIMEOUT_EN to add the
// timeout scenario.
module tb_axi_read_master;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic [DW-1:0] out_data;
    logic          out_last, out_valid, out_ready;
    logic          done, err;

    axi_read_master #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .done(done), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard: {last, data}
    logic [DW:0] exp_q[$];
    logic [DW:0] rx_q[$];

    // stimulus knobs
    int ready_mode    = 0;   // 0: always ready, 1: pattern 1,0,0 repeating
    int resp_err_beat = -1;
    int rlast_beat    = -1;
    bit slave_silent  = 0;
    int pat_i         = 0;

    // monitor state
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          ar_cyc = 0;
    logic        done_err = 1'b0;
    logic [7:0]  ar_seen_addr = '0;
    logic [7:0]  ar_seen_len = '0;
    int          stall_viol = 0;
    int          rready_viol = 0;
    bit          stall_prev = 0;
    logic [DW:0] stall_word = '0;

    // slave state
    bit         slv_busy = 0;
    logic [7:0] slv_addr = '0;
    logic [7:0] slv_len = '0;
    logic [2:0] slv_size = '0;
    int         slv_beat = 0;

    function automatic logic [DW-1:0] ram_word(input int a);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 8; j++) w[8*j +: 8] = 8'((a + j) % 256);
        return w;
    endfunction

    // ---------------- slave RAM model (drives at negedge+1) ----------------
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(negedge aclk); #1;
            if (!aresetn) begin
                slv_busy = 0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end else if (!slv_busy) begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b1;
                if (arvalid) begin
                    slv_addr = araddr; slv_len = arlen; slv_size = arsize;
                    slv_busy = 1; slv_beat = 0;
                end
            end else begin
                arready = 1'b0;
                if (slave_silent) begin
                    rvalid = 1'b0;
                end else begin
                    rvalid = 1'b1;
                    rdata  = ram_word(int'(slv_addr) + slv_beat * (1 << slv_size));
                    rresp  = (slv_beat == resp_err_beat) ? 2'b10 : 2'b00;
                    rlast  = (slv_beat == int'(slv_len)) || (slv_beat == rlast_beat);
                    if (rready) begin
                        slv_beat++;
                        if (slv_beat > int'(slv_len)) slv_busy = 0;
                    end
                end
            end
        end
    end

    // ---------------- consumer ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge aclk);
            out_ready = (ready_mode == 0) ? 1'b1 : ((pat_i % 3) == 0);
            pat_i++;
        end
    end

    // ---------------- monitor (samples at negedge+2) ----------------
    initial begin
        forever begin
            @(negedge aclk); #2;
            cyc++;
            if (!aresetn) begin
                stall_prev = 0;
            end else begin
                if (stall_prev && (out_valid !== 1'b1 || {out_last, out_data} !== stall_word))
                    stall_viol++;
                if (out_valid && !out_ready && rready) rready_viol++;
                if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
                stall_prev = out_valid && !out_ready;
                stall_word = {out_last, out_data};
                if (done) begin done_cnt++; done_err = err; done_cyc = cyc; end
                if (arvalid && arready) begin
                    ar_cyc = cyc; ar_seen_addr = araddr; ar_seen_len = arlen;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic [7:0] a, input logic [7:0] l, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin ok = 1; break; end
        end
        cmd_addr = a; cmd_len = l; cmd_size = 3'd2; cmd_valid = ok;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    // returns at negedge+3 of the cycle where done is high
    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk); #3;
            if (done === 1'b1) begin ok = 1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp++;
        if ({arvalid, rready, out_valid, out_last, done, err, cmd_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000001",
                     {arvalid, rready, out_valid, out_last, done, err, cmd_ready});
        end
        n_cmp++;
        if ({araddr, arlen, arsize, out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h want 0", {araddr, arlen, arsize, out_data});
        end
        n_cmp++;
        if (arburst !== 2'b01) begin
            n_fail++; $display("FAIL arburst: got %b want 01", arburst);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk); #3;
        n_cmp++;
        if ({cmd_ready, arvalid, done} !== 3'b100) begin
            n_fail++; $display("FAIL post_reset: got %b want 100", {cmd_ready, arvalid, done});
        end
    endtask

    // Runs one burst against the pre-loaded exp_q and checks the whole result
    task automatic test_burst(input string name, input logic [7:0] a, input logic [7:0] l,
                              input int rmode, input int resp_b, input int rlast_b,
                              input logic exp_err);
        bit ok;
        int d0, n;
        ready_mode = rmode; resp_err_beat = resp_b; rlast_beat = rlast_b;
        rx_q.delete(); stall_viol = 0; rready_viol = 0; d0 = done_cnt;
        issue_cmd(a, l, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL %s cmd_accept: got 0 want 1", name); end
        wait_done(2000, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL %s done_timeout: got 0 want 1", name); end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s cmd_ready_at_done: got %b want 0", name, cmd_ready);
        end
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d want %0d", name, rx_q.size(), exp_q.size());
        end
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s beat%0d: got %h want %h", name, i, rx_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_err !== exp_err) begin
            n_fail++; $display("FAIL %s err: got %b want %b", name, done_err, exp_err);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
        end
        n_cmp++;
        if ({ar_seen_addr, ar_seen_len} !== {a, l}) begin
            n_fail++;
            $display("FAIL %s ar_fields: got %h want %h", name, {ar_seen_addr, ar_seen_len}, {a, l});
        end
        n_cmp++;
        if (stall_viol != 0 || rready_viol != 0) begin
            n_fail++;
            $display("FAIL %s stall: got %0d/%0d violations want 0/0", name, stall_viol, rready_viol);
        end
        @(negedge aclk); #3;
        n_cmp++;
        if ({done, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s after_done: got %b want 01", name, {done, cmd_ready});
        end
        ready_mode = 0; resp_err_beat = -1; rlast_beat = -1;
        exp_q.delete();
    endtask

    task automatic test_basic();
        exp_q = '{33'h0_13121110, 33'h0_17161514, 33'h0_1B1A1918, 33'h1_1F1E1D1C};
        test_burst("basic", 8'h10, 8'd3, 0, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        exp_q = '{33'h0_13121110, 33'h0_17161514, 33'h0_1B1A1918, 33'h1_1F1E1D1C};
        test_burst("stall", 8'h10, 8'd3, 1, -1, -1, 1'b0);
    endtask

    task automatic test_rresp_err();
        exp_q = '{33'h0_33323130, 33'h1_37363534};
        test_burst("rresp_err", 8'h30, 8'd1, 0, 1, -1, 1'b1);
    endtask

    task automatic test_rlast_err();
        exp_q = '{33'h0_43424140, 33'h0_47464544, 33'h1_4B4A4948};
        test_burst("rlast_err", 8'h40, 8'd2, 1, -1, 0, 1'b1);
    endtask

    task automatic test_max_len();
        for (int k = 0; k < 256; k++) exp_q.push_back({k == 255, ram_word(k * 4)});
        test_burst("max_len", 8'h00, 8'd255, 0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        rx_q.delete(); d0 = done_cnt;
        exp_q = '{33'h1_83828180, 33'h0_93929190, 33'h1_97969594};
        issue_cmd(8'h80, 8'd0, ok);
        wait_done(200, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL b2b first_done: got 0 want 1"); end
        @(negedge aclk);
        cmd_addr = 8'h90; cmd_len = 8'd1; cmd_size = 3'd2; cmd_valid = 1'b1;
        #3;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b cmd_ready: got %b want 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
        wait_done(200, ok);
        n_cmp++;
        if (!ok || done_err !== 1'b0 || done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL b2b second_done: got ok=%0d err=%b pulses=%0d want 1/0/2",
                     ok, done_err, done_cnt - d0);
        end
        n_cmp++;
        if (rx_q.size() != 3) begin
            n_fail++; $display("FAIL b2b beat_count: got %0d want 3", rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b beat%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        rx_q.delete(); d0 = done_cnt;
        issue_cmd(8'h40, 8'd7, ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk); #3;
            if (rx_q.size() >= 2) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL mid_reset two_beats: got %0d want 2", rx_q.size()); end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, out_valid, out_last, rready, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_reset outputs: got %b want 000000",
                     {arvalid, out_valid, out_last, rready, done, err});
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #3;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset cmd_ready: got %b want 1", cmd_ready);
        end
        repeat (2) @(negedge aclk);
        #3;
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++; $display("FAIL mid_reset no_done: got %0d pulses want 0", done_cnt - d0);
        end
        exp_q = '{33'h1_23222120};
        test_burst("after_reset", 8'h20, 8'd0, 0, -1, -1, 1'b0);
    endtask

`ifdef AXI_READ_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        rx_q.delete();
        slave_silent = 1;
        issue_cmd(8'h50, 8'd3, ok);
        wait_done(100, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL timeout done: got 0 want 1"); end
        n_cmp++;
        if (done_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout err: got %b want 1", done_err);
        end
        // AR accepted on the edge after its sample; done rises 8 edges later
        n_cmp++;
        if (done_cyc - ar_cyc != 9) begin
            n_fail++; $display("FAIL timeout latency: got %0d want 9", done_cyc - ar_cyc);
        end
        n_cmp++;
        if (rx_q.size() != 0) begin
            n_fail++; $display("FAIL timeout beats: got %0d want 0", rx_q.size());
        end
        @(negedge aclk); #3;
        n_cmp++;
        if ({done, cmd_ready} !== 2'b01) begin
            n_fail++; $display("FAIL timeout idle: got %b want 01", {done, cmd_ready});
        end
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        slave_silent = 0;
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        aresetn = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        repeat (3) @(negedge aclk);
        test_reset();
        test_basic();
        test_stall();
        test_rresp_err();
        test_rlast_err();
        test_max_len();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_READ_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- AXI4 read-channel master that drives the AR/R ports of the team's AXI slave RAM.
- Accepts one read-burst command at a time on a valid/ready command port.
- Issues a single INCR burst on AR, collects R beats through a one-entry output register, and streams them out with a last marker.
- Reports completion with a done pulse and a burst-level error flag. Sits between test/DMA logic and the slave.

Parameters:
- DATA_WIDTH, 32, width of rdata and out_data in bits
- ADDRESS_WIDTH, 8, width of cmd_addr and araddr
- TIMEOUT_CYCLES, 64, idle R-channel limit; used only when the optional feature is compiled in

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_addr  in  ADDRESS_WIDTH  burst start byte address
- cmd_len  in  8  AXI len; beats = cmd_len+1
- cmd_size  in  3  AXI size; bytes per beat = 2**cmd_size
- araddr  out  ADDRESS_WIDTH  AR address
- arlen  out  8  AR len
- arsize  out  3  AR size
- arburst  out  2  AR burst type; constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- out_data  out  DATA_WIDTH  beat data to consumer
- out_last  out  1  marks final beat of burst
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer ready
- done  out  1  one-cycle pulse at burst completion
- err  out  1  valid with done; 1 if any rresp!=0 or rlast mismatch

Behaviour:
- Reset: state IDLE. arvalid=0, rready=0, out_valid=0, out_last=0, done=0, err=0, araddr/arlen/arsize/out_data=0, beat counter=0.
- States: IDLE, ADDR, DATA, FLUSH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/len/size into AR outputs, clear beat counter and error accumulator, go to ADDR. arvalid=1 the next cycle.
- ADDR:
  - arvalid held high; AR fields held stable until arready.
  - On arvalid&&arready: go to DATA.
- DATA:
  - rready = !out_valid || out_ready (combinational).
  - On rvalid&&rready: out_data<=rdata, out_valid<=1, beat counter +1.
  - out_last<=1 when the counter equals cmd_len (the final beat).
  - Error accumulator sets if rresp!=2'b00, if rlast=1 on a non-final beat, or if rlast=0 on the final beat.
  - Burst ends on the (len+1)th beat by count, never by rlast. Next state: FLUSH.
- Output register:
  - out_valid clears on out_ready when no new beat is loaded the same cycle.
  - Simultaneous drain and load keeps out_valid=1.
  - out_data/out_last are held stable while out_valid&&!out_ready.
- FLUSH:
  - rready=0.
  - When out_valid&&out_ready on the last beat: done=1 and err=accumulator for that single cycle, then IDLE.
  - cmd_ready goes 1 the cycle after done; back-to-back commands cost one idle cycle.
- Arithmetic: beat counter is 9 bits; len=255 gives 256 beats with no wrap. Addresses pass through unmodified; unaligned start is legal and handled by the slave.
- Reset mid-operation: everything returns to reset values immediately; no done pulse. The slave is reset by the same aresetn.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Optional Feature:
- Macro: AXI_READ_MASTER_TIMEOUT_EN.
- Defined:
  - A counter increments each DATA cycle with rready=1 and no rvalid, and clears on any R beat.
  - When it reaches TIMEOUT_CYCLES: drop rready, force err accumulator=1, go to FLUSH.
  - If a beat is still held in the output register, the done/err pulse is issued after it drains, with out_last forced to 1 on that beat. With no beat held, done=1/err=1 pulse the next cycle.
- Undefined: no counter; the master waits indefinitely in DATA.

Test Plan:
- Slave RAM byte i = i. cmd addr=0x10, len=3, size=2, out_ready=1 -> out_data 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C; out_last only on 4th; done pulse with err=0.
- Same command with out_ready toggling 1,0,0,1,... -> identical data order, no beat lost or duplicated, out_data stable while stalled, rready low whenever out_valid&&!out_ready.
- Slave model returns rresp=2'b10 on beat 2 of a len=1 burst -> both beats delivered, done with err=1.
- Slave model asserts rlast on beat 1 of a len=2 burst -> master still takes 3 beats, done with err=1.
- Assert aresetn=0 during DATA after 2 beats -> next edge: arvalid=0, out_valid=0, cmd_ready=1 after release, no done; a new len=0 command completes normally.
- With AXI_READ_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts rvalid -> 8 cycles after AR handshake done=1, err=1, return to IDLE.
